// File: rtl/simon_round_engine.sv
// Simon Says round engine: LFSR prompt generator, key-press detector and
// round countdown, driven by the game controller.
module simon_round_engine #(
   parameter int TICKS_PER_STEP = 1000,
   parameter int BASE_STEPS     = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sd_srst,
   input  logic       mem_en,
   input  logic       fr_en,
   input  logic [3:0] score,
   input  logic [3:0] keys,
   output logic [3:0] prompt_key,
   output logic       simon_says,
   output logic       sk_strobe,
   output logic       round_passed,
   output logic       sd_is_empty,
   output logic [7:0] count
);

   localparam int            PW         = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_STEP - 1);
   localparam logic [7:0]    BASE       = 8'(BASE_STEPS);
   localparam logic [7:0]    LFSR_SEED  = 8'h5A;

   logic [7:0]    lfsr_q, lfsr_d;
   logic [3:0]    prompt_key_q, prompt_key_d;
   logic          simon_says_q, simon_says_d;
   logic          sk_strobe_q, sk_strobe_d;
   logic          round_passed_q, round_passed_d;
   logic [7:0]    count_q, count_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [3:0]    keys_q, keys_d;
   logic          mem_en_q, mem_en_d;

   logic          lfsr_fb;
   logic          prompt_latch;
   logic          key_press;
   logic          key_accept;
   logic          key_hit;

   assign lfsr_fb      = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
   assign prompt_latch = mem_en_q & ~mem_en;
   assign key_press    = (keys_q == 4'b0000) && (keys != 4'b0000);
   assign key_accept   = key_press & ~fr_en;
   // Exact match against the prompt currently shown, so chords never pass.
   assign key_hit      = key_accept && simon_says_q && (keys == prompt_key_q);

   always_comb begin
      lfsr_d = lfsr_q;
      if (mem_en) begin
         lfsr_d = {lfsr_q[6:0], lfsr_fb};
      end
   end

   always_comb begin
      prompt_key_d = prompt_key_q;
      simon_says_d = simon_says_q;
      if (prompt_latch) begin
         simon_says_d = lfsr_q[7] | lfsr_q[6];
         unique case (lfsr_q[1:0])
            2'd0:    prompt_key_d = 4'b0001;
            2'd1:    prompt_key_d = 4'b0010;
            2'd2:    prompt_key_d = 4'b0100;
            default: prompt_key_d = 4'b1000;
         endcase
      end
   end

   // A correct press wins over the clear that a new prompt brings.
   always_comb begin
      round_passed_d = round_passed_q;
      if (key_hit) begin
         round_passed_d = 1'b1;
      end else if (prompt_latch) begin
         round_passed_d = 1'b0;
      end
   end

   always_comb begin
      sk_strobe_d = key_accept;
      keys_d      = keys;
      mem_en_d    = mem_en;
   end

   always_comb begin
      count_d = count_q;
      presc_d = presc_q;
      if (sd_srst) begin
         count_d = BASE - {4'b0000, score};
         presc_d = '0;
      end else if (count_q != 8'd0) begin
         if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            count_d = count_q - 8'd1;
         end else begin
            presc_d = presc_q + 1'b1;
         end
      end else begin
         presc_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q         <= LFSR_SEED;
         prompt_key_q   <= 4'b0000;
         simon_says_q   <= 1'b0;
         sk_strobe_q    <= 1'b0;
         round_passed_q <= 1'b0;
         count_q        <= 8'd0;
         presc_q        <= '0;
         keys_q         <= 4'b0000;
         mem_en_q       <= 1'b0;
      end else begin
         lfsr_q         <= lfsr_d;
         prompt_key_q   <= prompt_key_d;
         simon_says_q   <= simon_says_d;
         sk_strobe_q    <= sk_strobe_d;
         round_passed_q <= round_passed_d;
         count_q        <= count_d;
         presc_q        <= presc_d;
         keys_q         <= keys_d;
         mem_en_q       <= mem_en_d;
      end
   end

   assign prompt_key   = prompt_key_q;
   assign simon_says   = simon_says_q;
   assign sk_strobe    = sk_strobe_q;
   assign round_passed = round_passed_q;
   assign count        = count_q;
   assign sd_is_empty  = (count_q == 8'd0);

endmodule

// File: tb/tb_simon_round_engine.sv
// Bench for simon_round_engine: table-driven countdown and prompt vectors,
// hand-written key/latch/reset sequences, then random traffic against a model.
module tb_simon_round_engine;

   localparam int T = 2;
   localparam int B = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sd_srst = 1'b0;
   logic       mem_en = 1'b0;
   logic       fr_en = 1'b0;
   logic [3:0] score = 4'd0;
   logic [3:0] keys = 4'd0;
   logic [3:0] prompt_key;
   logic       simon_says;
   logic       sk_strobe;
   logic       round_passed;
   logic       sd_is_empty;
   logic [7:0] count;

   int checks = 0;
   int failures = 0;

   simon_round_engine #(.TICKS_PER_STEP(T), .BASE_STEPS(B)) dut (
      .clk(clk), .rst(rst), .sd_srst(sd_srst), .mem_en(mem_en), .fr_en(fr_en),
      .score(score), .keys(keys), .prompt_key(prompt_key), .simon_says(simon_says),
      .sk_strobe(sk_strobe), .round_passed(round_passed), .sd_is_empty(sd_is_empty),
      .count(count)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [7:0] lfsr_step(input logic [7:0] x);
      logic fb;
      fb = ($countones(x & 8'hB8) % 2) == 1;
      return 8'((x << 1) | {7'd0, fb});
   endfunction

   function automatic logic [7:0] lfsr_adv(input int n);
      logic [7:0] x;
      x = 8'h5A;
      for (int i = 0; i < n; i++) x = lfsr_step(x);
      return x;
   endfunction

   function automatic logic [3:0] key_of(input logic [7:0] x);
      return 4'(1 << x[1:0]);
   endfunction

   function automatic logic says_of(input logic [7:0] x);
      return x >= 8'h40;
   endfunction

   function automatic int next_says(input int from);
      int n;
      n = from;
      while (!says_of(lfsr_adv(n)) && n < from + 64) n++;
      return n;
   endfunction

   logic [7:0] m_lfsr = 8'h5A;
   logic [3:0] m_prompt = 4'd0;
   logic       m_says = 1'b0;
   logic       m_strobe = 1'b0;
   logic       m_passed = 1'b0;
   int         m_rem = 0;
   logic [3:0] m_keys_prev = 4'd0;
   logic       m_mem_prev = 1'b0;
   logic       m_press, m_latch, m_hit;
   logic [7:0] m_count;

   assign m_press = (m_keys_prev == 4'd0) && (keys != 4'd0) && !fr_en;
   assign m_latch = m_mem_prev && !mem_en;
   assign m_hit   = m_press && m_says && (keys == m_prompt);
   assign m_count = 8'((m_rem + T - 1) / T);

   always @(posedge clk) begin
      if (rst) begin
         m_lfsr <= 8'h5A; m_prompt <= 4'd0; m_says <= 1'b0; m_strobe <= 1'b0;
         m_passed <= 1'b0; m_rem <= 0; m_keys_prev <= 4'd0; m_mem_prev <= 1'b0;
      end else begin
         m_keys_prev <= keys;
         m_mem_prev  <= mem_en;
         m_strobe    <= m_press;
         if (mem_en) m_lfsr <= lfsr_step(m_lfsr);
         if (m_latch) begin
            m_prompt <= key_of(m_lfsr);
            m_says   <= says_of(m_lfsr);
         end
         if (m_hit) m_passed <= 1'b1;
         else if (m_latch) m_passed <= 1'b0;
         if (sd_srst) m_rem <= ((B - int'(score)) & 255) * T;
         else if (m_rem > 0) m_rem <= m_rem - 1;
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; sd_srst = 1'b0; mem_en = 1'b0; fr_en = 1'b0; keys = 4'd0; score = 4'd0;
      tick();
      rst = 1'b0;
   endtask

   task automatic latch_after(input int n);
      mem_en = 1'b1;
      repeat (n) tick();
      mem_en = 1'b0;
      tick();
   endtask

   typedef struct {
      logic [3:0] sc;
      logic [7:0] exp_count;
      int         exp_cycles;
   } cd_vec_t;

   cd_vec_t cd_tab[4];
   int      pr_tab[5];

   initial begin
      int n, m, strobes;
      logic [3:0] p, wrong;
      logic [7:0] x;

      cd_tab[0] = '{4'd0, 8'd16, 32};
      cd_tab[1] = '{4'd9, 8'd7, 14};
      cd_tab[2] = '{4'd5, 8'd11, 22};
      cd_tab[3] = '{4'd15, 8'd1, 2};
      pr_tab = '{1, 3, 7, 12, 20};

      // Reset state
      do_reset();
      chk("rst_count", count, 8'd0);
      chk("rst_empty", sd_is_empty, 1'b1);
      chk("rst_prompt", prompt_key, 4'd0);
      chk("rst_says", simon_says, 1'b0);
      chk("rst_strobe", sk_strobe, 1'b0);
      chk("rst_passed", round_passed, 1'b0);

      // Countdown load and duration table
      for (int i = 0; i < 4; i++) begin
         sd_srst = 1'b1; score = cd_tab[i].sc;
         tick();
         chk("cd_load", count, cd_tab[i].exp_count);
         chk("cd_not_empty", sd_is_empty, 1'b0);
         sd_srst = 1'b0;
         n = 0;
         while (!sd_is_empty && n < 600) begin
            tick();
            n++;
         end
         chk("cd_duration", n, cd_tab[i].exp_cycles);
      end

      // Prompt latch table from the reset seed
      for (int i = 0; i < 5; i++) begin
         do_reset();
         latch_after(pr_tab[i]);
         x = lfsr_adv(pr_tab[i]);
         chk("pr_key", prompt_key, key_of(x));
         chk("pr_says", simon_says, says_of(x));
         chk("pr_passed", round_passed, 1'b0);
      end

      // Correct press, hold, then a wrong press keeps the pass
      do_reset();
      n = next_says(1);
      latch_after(n);
      p = key_of(lfsr_adv(n));
      chk("ok_says", simon_says, 1'b1);
      keys = p;
      tick();
      chk("ok_strobe", sk_strobe, 1'b1);
      chk("ok_passed", round_passed, 1'b1);
      strobes = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (sk_strobe) strobes++;
      end
      chk("hold_no_strobe", strobes, 0);
      keys = 4'd0; tick();
      keys = {p[2:0], p[3]}; tick();
      chk("sticky_strobe", sk_strobe, 1'b1);
      chk("sticky_passed", round_passed, 1'b1);
      keys = 4'd0; tick();

      // Wrong key, chord, frozen press
      do_reset();
      n = next_says(1);
      latch_after(n);
      p = key_of(lfsr_adv(n));
      wrong = {p[2:0], p[3]};
      keys = wrong; tick();
      chk("wrong_strobe", sk_strobe, 1'b1);
      chk("wrong_passed", round_passed, 1'b0);
      keys = 4'd0; tick();
      keys = p | wrong; tick();
      chk("chord_strobe", sk_strobe, 1'b1);
      chk("chord_passed", round_passed, 1'b0);
      keys = 4'd0; tick();
      fr_en = 1'b1; keys = p; tick();
      chk("frz_strobe", sk_strobe, 1'b0);
      chk("frz_passed", round_passed, 1'b0);
      keys = 4'd0; fr_en = 1'b0; tick();

      // Matching press coincides with a new prompt latch
      do_reset();
      n = next_says(1);
      latch_after(n);
      p = key_of(lfsr_adv(n));
      m = 5;
      mem_en = 1'b1;
      repeat (m) tick();
      mem_en = 1'b0; keys = p;
      tick();
      x = lfsr_adv(n + m);
      chk("both_passed", round_passed, 1'b1);
      chk("both_strobe", sk_strobe, 1'b1);
      chk("both_key", prompt_key, key_of(x));
      chk("both_says", simon_says, says_of(x));
      keys = 4'd0; tick();

      // Reset mid-countdown while a key is held
      do_reset();
      sd_srst = 1'b1; score = 4'd0; tick();
      sd_srst = 1'b0; keys = 4'b0100; mem_en = 1'b1;
      repeat (14) tick();
      chk("mid_count", count, 8'd9);
      rst = 1'b1; tick();
      chk("mr_count", count, 8'd0);
      chk("mr_empty", sd_is_empty, 1'b1);
      chk("mr_prompt", prompt_key, 4'd0);
      chk("mr_says", simon_says, 1'b0);
      chk("mr_strobe", sk_strobe, 1'b0);
      chk("mr_passed", round_passed, 1'b0);
      rst = 1'b0; keys = 4'd0; mem_en = 1'b0;
      latch_after(3);
      chk("mr_seed_key", prompt_key, key_of(lfsr_adv(3)));
      chk("mr_seed_says", simon_says, says_of(lfsr_adv(3)));

      // Random traffic against the model
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         rst     = ($urandom_range(0, 999) < 3);
         sd_srst = ($urandom_range(0, 99) < 3);
         score   = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 9) < 2) mem_en = ~mem_en;
         fr_en   = ($urandom_range(0, 99) < 15);
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: keys = 4'd0;
            5, 6, 7:       keys = m_prompt;
            default:       keys = 4'($urandom_range(0, 15));
         endcase
         tick();
         chk("rnd_prompt", prompt_key, m_prompt);
         chk("rnd_says", simon_says, m_says);
         chk("rnd_strobe", sk_strobe, m_strobe);
         chk("rnd_passed", round_passed, m_passed);
         chk("rnd_count", count, m_count);
         chk("rnd_empty", sd_is_empty, m_rem == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
